// File: rtl/vector_dot_accumulator_if.sv
// Element stream in, dot-product result and progress status out.
interface vector_dot_accumulator_if #(
  parameter int ELEMENT_WIDTH = 3,
  parameter int GUARD_BITS    = 8
);
  localparam int EW = ELEMENT_WIDTH * 8;
  localparam int RW = 2 * EW + GUARD_BITS;

  logic [EW-1:0] element;
  logic          element_ready;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          phase_b;
  logic [7:0]    elem_index;

  // Producer of elements / consumer of results.
  modport master (
    output element, element_ready,
    input  result, result_valid, phase_b, elem_index
  );

  // The accumulator itself.
  modport slave (
    input  element, element_ready,
    output result, result_valid, phase_b, elem_index
  );
endinterface

// File: rtl/vector_dot_accumulator.sv
// Unsigned dot product of two streamed vectors: A is buffered, then each
// B element is multiplied by the matching A entry and accumulated. The
// final sum is registered with a one-cycle valid strobe.
module vector_dot_accumulator #(
  parameter int ELEMENT_WIDTH = 3,
  parameter int VECTOR_LENGTH = 4,
  parameter int GUARD_BITS    = 8
) (
  input logic                    clk,
  input logic                    reset,
  vector_dot_accumulator_if.slave bus
);
  localparam int EW = ELEMENT_WIDTH * 8;
  localparam int RW = 2 * EW + GUARD_BITS;
  // A-buffer address width; the buffer is rounded up to a power of two so
  // the index slice always addresses it exactly.
  localparam int IW = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam logic [7:0] LAST = 8'(VECTOR_LENGTH - 1);

  typedef enum logic {LOAD_A, MAC_B} state_t;

  state_t        state, state_next;
  logic [7:0]    idx, idx_next;
  logic [RW-1:0] acc, acc_next;
  logic [RW-1:0] res, res_next;
  logic          valid, valid_next;

  logic [EW-1:0]   a_buf [2**IW];
  logic [IW-1:0]   a_sel;
  logic [2*EW-1:0] product;
  logic [RW-1:0]   sum;

  assign a_sel   = idx[IW-1:0];
  assign product = (2*EW)'(a_buf[a_sel]) * (2*EW)'(bus.element);
  assign sum     = acc + RW'(product);

  // A-buffer capture during the load phase; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && bus.element_ready && state == LOAD_A)
      a_buf[a_sel] <= bus.element;
  end

  // State, index, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_A;
      idx   <= '0;
      acc   <= '0;
      res   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      acc   <= acc_next;
      res   <= res_next;
      valid <= valid_next;
    end
  end

  // Next-state logic: only an element_ready cycle makes progress.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    acc_next   = acc;
    res_next   = res;
    valid_next = 1'b0;
    if (bus.element_ready) begin
      unique case (state)
        LOAD_A: begin
          if (idx == LAST) begin
            idx_next   = '0;
            acc_next   = '0;
            state_next = MAC_B;
          end else begin
            idx_next = idx + 8'd1;
          end
        end
        MAC_B: begin
          if (idx == LAST) begin
            res_next   = sum;
            valid_next = 1'b1;
            acc_next   = '0;
            idx_next   = '0;
            state_next = LOAD_A;
          end else begin
            acc_next = sum;
            idx_next = idx + 8'd1;
          end
        end
        default: state_next = LOAD_A;
      endcase
    end
  end

  assign bus.result       = res;
  assign bus.result_valid = valid;
  assign bus.phase_b      = (state == MAC_B);
  assign bus.elem_index   = idx;
endmodule

// File: tb/tb_vector_dot_accumulator.sv
// Bench for vector_dot_accumulator: two instances (default EW=3/N=4 and
// EW=2/N=1), a stream-level reference model checked every cycle, plus
// literal expectations for the directed cases.
module tb_vector_dot_accumulator;
  logic clk;
  logic rst0, rst1;
  int   checks = 0;
  int   errors = 0;

  vector_dot_accumulator_if #(.ELEMENT_WIDTH(3), .GUARD_BITS(8)) if0 ();
  vector_dot_accumulator_if #(.ELEMENT_WIDTH(2), .GUARD_BITS(8)) if1 ();

  vector_dot_accumulator #(.ELEMENT_WIDTH(3), .VECTOR_LENGTH(4), .GUARD_BITS(8))
    u0 (.clk(clk), .reset(rst0), .bus(if0));
  vector_dot_accumulator #(.ELEMENT_WIDTH(2), .VECTOR_LENGTH(1), .GUARD_BITS(8))
    u1 (.clk(clk), .reset(rst1), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a pair is 2N stream elements; the result is the sum of
  // A[i]*B[i] modulo 2^RW, visible the cycle after the last element.
  longint unsigned m_elems [2][8];
  int              m_cnt   [2];
  longint unsigned m_res   [2];
  bit              m_valid [2];
  int              pulses  [2];

  function automatic int nlen(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic longint unsigned rmask(int k);
    return (k == 0) ? ((64'h1 << 56) - 1) : ((64'h1 << 40) - 1);
  endfunction

  function automatic void model_step(int k, bit r, bit rdy, longint unsigned el);
    longint unsigned s;
    int n;
    n = nlen(k);
    if (r) begin
      m_cnt[k]   = 0;
      m_res[k]   = 0;
      m_valid[k] = 0;
    end else begin
      m_valid[k] = 0;
      if (rdy) begin
        m_elems[k][m_cnt[k]] = el;
        m_cnt[k]++;
        if (m_cnt[k] == 2 * n) begin
          s = 0;
          for (int i = 0; i < n; i++) s += m_elems[k][i] * m_elems[k][n + i];
          m_res[k]   = s & rmask(k);
          m_valid[k] = 1;
          m_cnt[k]   = 0;
        end
      end
    end
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(int k, longint unsigned res, bit vld, bit ph, int idx);
    int n;
    n = nlen(k);
    if (vld) pulses[k]++;
    chk($sformatf("u%0d.result", k), res, m_res[k]);
    chk($sformatf("u%0d.result_valid", k), vld, m_valid[k]);
    chk($sformatf("u%0d.phase_b", k), ph, (m_cnt[k] >= n) ? 1 : 0);
    chk($sformatf("u%0d.elem_index", k), idx, m_cnt[k] % n);
  endtask

  // Per-cycle compare for instance 0: model sees the sampled inputs, outputs checked #1 later.
  always @(posedge clk) begin
    model_step(0, rst0, if0.element_ready, longint'(if0.element));
    #1 check_obs(0, longint'(if0.result), if0.result_valid, if0.phase_b, int'(if0.elem_index));
  end

  // Per-cycle compare for instance 1.
  always @(posedge clk) begin
    model_step(1, rst1, if1.element_ready, longint'(if1.element));
    #1 check_obs(1, longint'(if1.result), if1.result_valid, if1.phase_b, int'(if1.elem_index));
  end

  task automatic send0(longint unsigned v, int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if0.element_ready = 1'b0;
    end
    @(negedge clk);
    if0.element       = 24'(v);
    if0.element_ready = 1'b1;
  endtask

  task automatic send1(longint unsigned v);
    @(negedge clk);
    if1.element       = 16'(v);
    if1.element_ready = 1'b1;
  endtask

  task automatic idle(int n);
    for (int g = 0; g < n; g++) begin
      @(negedge clk);
      if0.element_ready = 1'b0;
      if1.element_ready = 1'b0;
    end
  endtask

  task automatic pair0(longint unsigned v [8], int maxgap);
    for (int i = 0; i < 8; i++) send0(v[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #2;
  endtask

  longint unsigned vec [8];
  int p0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_res[k] = 0; m_valid[k] = 0; pulses[k] = 0;
    end
    rst0 = 1'b1; rst1 = 1'b1;
    if0.element = '0; if0.element_ready = 1'b0;
    if1.element = '0; if1.element_ready = 1'b0;
    after_edge();
    chk("reset_phase_b", if0.phase_b, 0);
    chk("reset_elem_index", if0.elem_index, 0);
    chk("reset_result", if0.result, 0);
    chk("reset_result_valid", if0.result_valid, 0);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    idle(2);

    // 1,2,3,0 . 4,5,6,0 -> 32
    vec = '{1, 2, 3, 0, 4, 5, 6, 0};
    pair0(vec, 0);
    after_edge();
    chk("small_result", if0.result, 32);
    chk("small_valid", if0.result_valid, 1);
    idle(2);
    chk("small_valid_drop", if0.result_valid, 0);
    chk("small_phase_back", if0.phase_b, 0);
    chk("small_result_hold", if0.result, 32);

    // all 0xFF -> 260100
    vec = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    pair0(vec, 0);
    after_edge();
    chk("ff_result", if0.result, 260100);
    idle(1);

    // full-width operands, no gaps then random gaps
    vec = '{24'hFFFFFF, 0, 0, 1, 24'hFFFFFF, 7, 9, 24'h10};
    pair0(vec, 0);
    after_edge();
    chk("wide_result", if0.result, 64'hFFFFFE000011);
    idle(3);
    p0 = pulses[0];
    pair0(vec, 5);
    after_edge();
    chk("wide_gap_result", if0.result, 64'hFFFFFE000011);
    idle(4);
    chk("wide_gap_pulses", pulses[0] - p0, 1);

    // back-to-back pairs -> 23 then 30
    vec = '{2, 3, 0, 0, 4, 5, 9, 9};
    pair0(vec, 0);
    after_edge();
    chk("b2b_first", if0.result, 23);
    vec = '{1, 1, 0, 0, 10, 20, 7, 7};
    pair0(vec, 0);
    after_edge();
    chk("b2b_second", if0.result, 30);
    chk("b2b_second_valid", if0.result_valid, 1);
    idle(2);

    // reset mid-way through B, coinciding with an element
    for (int i = 0; i < 6; i++) send0(i + 1, 0);
    @(negedge clk);
    rst0 = 1'b1; if0.element = 24'd99; if0.element_ready = 1'b1;
    after_edge();
    chk("rst_mid_phase_b", if0.phase_b, 0);
    chk("rst_mid_elem_index", if0.elem_index, 0);
    chk("rst_mid_result", if0.result, 0);
    chk("rst_mid_valid", if0.result_valid, 0);
    @(negedge clk);
    rst0 = 1'b0; if0.element_ready = 1'b0;
    vec = '{1, 2, 3, 4, 5, 6, 7, 8};
    pair0(vec, 1);
    after_edge();
    chk("rst_fresh_result", if0.result, 70);
    idle(2);

    // N=1 instance: phase toggles per element
    send1(16'h1234);
    after_edge();
    chk("n1_phase_after_a", if1.phase_b, 1);
    send1(16'h0010);
    after_edge();
    chk("n1_result", if1.result, 64'h12340);
    chk("n1_phase_after_b", if1.phase_b, 0);
    send1(3);
    send1(5);
    after_edge();
    chk("n1_b2b_result", if1.result, 15);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
